// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: opcodes, user fields and channel structs
// shared by the pad host and its memory-side partner.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    localparam tl_a_user_t TL_A_USER_DEFAULT = '{
        rsvd:       5'h0,
        instr_type: 4'h9,
        cmd_intg:   7'h0,
        data_intg:  7'h0
    };

    typedef struct packed {
        logic       a_valid;
        tl_a_op_e   a_opcode;
        logic [2:0] a_param;
        logic [1:0] a_size;
        logic [7:0] a_source;
        logic [31:0] a_address;
        logic [3:0] a_mask;
        logic [31:0] a_data;
        tl_a_user_t a_user;
        logic       d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic       d_valid;
        tl_d_op_e   d_opcode;
        logic [2:0] d_param;
        logic [1:0] d_size;
        logic [7:0] d_source;
        logic [0:0] d_sink;
        logic [31:0] d_data;
        tl_d_user_t d_user;
        logic       d_error;
        logic       a_ready;
    } tl_d2h_t;

    localparam tl_h2d_t TL_H2D_DEFAULT = '{
        a_valid:   1'b0,
        a_opcode:  PutFullData,
        a_param:   3'h0,
        a_size:    2'h0,
        a_source:  8'h0,
        a_address: 32'h0,
        a_mask:    4'h0,
        a_data:    32'h0,
        a_user:    TL_A_USER_DEFAULT,
        d_ready:   1'b1
    };

endpackage

// File: rtl/tlul_pad_host.sv
// tlul_pad_host: a rising edge on the go pad issues exactly one TL-UL Get or
// PutFullData, waits for its response (or a timeout) and reports read data
// and error status on registered pad-side outputs.
module tlul_pad_host
    import tlul_pkg::*;
#(
    parameter logic [31:0] AddrBase      = 32'h0000_0000,
    parameter logic [15:0] TimeoutCycles = 16'd1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       go_i,
    input  logic       if_read_i,
    input  logic [3:0] addr_i,
    input  logic [3:0] wdata_i,
    output tl_h2d_t    tl_o,
    input  tl_d2h_t    tl_i,
    output logic [3:0] r_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam logic [15:0] TimeoutLast = TimeoutCycles - 16'd1;

    state_e      state_r;
    logic [15:0] cnt_r;
    logic        is_read_r;
    logic [3:0]  addr_r;
    logic [3:0]  wdata_r;
    logic        sync1_r;
    logic        sync2_r;
    logic        sync2_q_r;
    logic [1:0]  fill_r;
    logic        armed_r;
    logic        launch_s;
    logic        timeout_s;
    logic        unused_tl_s;

    // Byte address of a word index, wrapping at 32 bits.
    function automatic logic [31:0] word_addr(input logic [3:0] idx);
        return AddrBase + {26'b0, idx, 2'b00};
    endfunction

    // A response is bad if flagged, or if its opcode does not match the request kind.
    function automatic logic rsp_bad(input logic is_read, input logic d_error,
                                     input tl_d_op_e d_opcode);
        logic op_ok;
        if (is_read) begin
            op_ok = (d_opcode == AccessAckData);
        end else begin
            op_ok = (d_opcode == AccessAck);
        end
        return d_error | ~op_ok;
    endfunction

    // Pad synchroniser and edge history; armed_r blocks a level held through
    // reset from looking like a rising edge once the flops refill.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            sync2_q_r <= 1'b0;
            fill_r    <= 2'b00;
            armed_r   <= 1'b0;
        end else begin
            sync1_r   <= go_i;
            sync2_r   <= sync1_r;
            sync2_q_r <= sync2_r;
            fill_r    <= {fill_r[0], 1'b1};
            if (fill_r[1] && !sync2_r) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    assign launch_s  = armed_r & sync2_r & ~sync2_q_r;
    assign timeout_s = (cnt_r >= TimeoutLast);

    // Transaction sequencer with registered pad-side status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            is_read_r <= 1'b0;
            addr_r    <= 4'h0;
            wdata_r   <= 4'h0;
            r_data_o  <= 4'h0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        is_read_r <= if_read_i;
                        addr_r    <= addr_i;
                        wdata_r   <= wdata_i;
                        err_o     <= 1'b0;
                        cnt_r     <= 16'd0;
                        busy_o    <= 1'b1;
                        state_r   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tl_i.a_ready) begin
                        cnt_r   <= cnt_r + 16'd1;
                        state_r <= ST_RSP;
                    end else if (timeout_s) begin
                        err_o   <= 1'b1;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RSP: begin
                    if (tl_i.d_valid) begin
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                        if (rsp_bad(is_read_r, tl_i.d_error, tl_i.d_opcode)) begin
                            err_o <= 1'b1;
                        end else if (is_read_r) begin
                            r_data_o <= tl_i.d_data[3:0];
                        end
                    end else if (timeout_s) begin
                        err_o   <= 1'b1;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // A-channel decode: request fields only while in REQ, idle defaults otherwise.
    always_comb begin
        tl_o = TL_H2D_DEFAULT;
        if (state_r == ST_REQ) begin
            tl_o.a_valid   = 1'b1;
            tl_o.a_opcode  = is_read_r ? Get : PutFullData;
            tl_o.a_param   = 3'h0;
            tl_o.a_size    = 2'h2;
            tl_o.a_source  = 8'h0;
            tl_o.a_address = word_addr(addr_r);
            tl_o.a_mask    = 4'hf;
            tl_o.a_data    = is_read_r ? 32'h0 : {28'h0, wdata_r};
            tl_o.a_user    = TL_A_USER_DEFAULT;
        end else begin
            tl_o.a_valid = 1'b0;
        end
        tl_o.d_ready = 1'b1;
    end

    // Response fields this host never looks at.
    assign unused_tl_s = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink,
                           tl_i.d_user, tl_i.d_data[31:4]};

endmodule

// File: tb/tb_tlul_pad_host.sv
// Randomised scoreboard bench for tlul_pad_host with a behavioural memory
// responder; A-channel and done-pulse monitors check against queued expectations.
module tb_tlul_pad_host;
    import tlul_pkg::*;

    localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
    localparam logic [15:0] TIMEOUT   = 16'd8;
    localparam int M_OK = 0, M_NO_RSP = 1, M_NO_RDY = 2, M_RESET = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       go;
    logic       if_read;
    logic [3:0] addr;
    logic [3:0] wdata;
    tl_h2d_t    tl_h;
    tl_d2h_t    tl_d;
    logic [3:0] r_data;
    logic       busy;
    logic       done;
    logic       err;

    tlul_pad_host #(.AddrBase(ADDR_BASE), .TimeoutCycles(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .go_i(go), .if_read_i(if_read),
        .addr_i(addr), .wdata_i(wdata), .tl_o(tl_h), .tl_i(tl_d),
        .r_data_o(r_data), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; tl_a_op_e op; logic [31:0] data; } req_t;
    typedef struct { logic err; logic [3:0] rdata; } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    rsp_t        mon_r;
    logic [31:0] mem [16];
    logic [3:0]  model_rdata;
    int          checks = 0;
    int          errors = 0;
    int          handshakes = 0;
    int          exp_handshakes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // A-channel monitor: fields must match the oldest expected request every valid cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("d_ready", 32'(tl_h.d_ready), 32'd1);
            if (tl_h.a_valid) begin
                if (req_q.size() == 0) begin
                    note_fail("unexpected_request");
                end else begin
                    chk("a_address", tl_h.a_address, req_q[0].addr);
                    chk("a_opcode", 32'(tl_h.a_opcode), 32'(req_q[0].op));
                    chk("a_data", tl_h.a_data, req_q[0].data);
                    chk("a_mask", 32'(tl_h.a_mask), 32'hf);
                    chk("a_size", 32'(tl_h.a_size), 32'd2);
                    chk("a_param_source", 32'({tl_h.a_param, tl_h.a_source}), 32'd0);
                    chk("a_user", 32'(tl_h.a_user), 32'(TL_A_USER_DEFAULT));
                    if (tl_d.a_ready) begin
                        void'(req_q.pop_front());
                        handshakes++;
                    end
                end
            end
        end
    end

    // Completion monitor: each done pulse retires one expected outcome.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (rsp_q.size() == 0) begin
                note_fail("unexpected_done");
            end else begin
                mon_r = rsp_q.pop_front();
                chk("err_o", 32'(err), 32'(mon_r.err));
                chk("r_data_o", 32'(r_data), 32'(mon_r.rdata));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic run_txn(input bit rd, input logic [3:0] a, input logic [3:0] wd,
                           input int rdy_dly, input int rsp_dly, input bit inj_err,
                           input bit bad_op, input int mode, input bit poke);
        int   n;
        bit   seen;
        bit   bad;
        req_t rq;
        rsp_t rs;
        logic [31:0] rd_val;
        go = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if_read = rd;
        addr    = a;
        wdata   = wd;
        go      = 1'b1;
        rd_val  = mem[a];
        rq.addr = ADDR_BASE + 32'(a) * 32'd4;
        rq.op   = rd ? Get : PutFullData;
        rq.data = rd ? 32'h0 : {28'h0, wd};
        req_q.push_back(rq);
        bad = inj_err || bad_op || (mode != M_OK);
        if (!bad && rd) model_rdata = rd_val[3:0];
        if (!bad && !rd) mem[a] = {28'h0, wd};
        rs.err   = bad;
        rs.rdata = model_rdata;
        rsp_q.push_back(rs);
        if (mode != M_NO_RDY) exp_handshakes++;

        n = 0;
        seen = 1'b0;
        while (!seen && n < 6) begin
            @(posedge clk);
            n++;
            #1;
            seen = tl_h.a_valid;
        end
        chk("launch_latency", n, 32'd3);
        if (!seen) begin
            req_q.delete();
            rsp_q.delete();
            return;
        end
        chk("busy_at_launch", 32'(busy), 32'd1);
        chk("err_cleared_at_launch", 32'(err), 32'd0);
        go = 1'b0;

        if (mode == M_NO_RDY) begin
            n = 0;
            while (!done && n < 20) begin
                @(posedge clk);
                n++;
                #1;
            end
            chk("req_timeout_edges", n, 32'd8);
            chk("req_never_accepted", req_q.size(), 32'd1);
            req_q.delete();
        end else begin
            for (int k = 1; k <= rdy_dly; k++) begin
                @(posedge clk);
                #1;
                if (poke && k == 2) go = 1'b1;
            end
            tl_d.a_ready = 1'b1;
            @(posedge clk);
            #1;
            tl_d.a_ready = 1'b0;
            if (mode == M_RESET) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_r_data", 32'(r_data), 32'd0);
                chk("rst_err", 32'(err), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_a_valid", 32'(tl_h.a_valid), 32'd0);
                rst_n = 1'b1;
                void'(rsp_q.pop_back());
                model_rdata = 4'h0;
            end else if (mode == M_NO_RSP) begin
                n = rdy_dly + 1;
                while (!done && n < 20) begin
                    @(posedge clk);
                    n++;
                    #1;
                end
                chk("rsp_timeout_edges", n, 32'd8);
                @(posedge clk);
                #1;
                tl_d.d_valid  = 1'b1;
                tl_d.d_opcode = rd ? AccessAckData : AccessAck;
                tl_d.d_error  = 1'b0;
                tl_d.d_data   = 32'($urandom());
                @(posedge clk);
                #1;
                tl_d.d_valid = 1'b0;
                @(posedge clk);
                #1;
                chk("late_rsp_busy", 32'(busy), 32'd0);
                chk("late_rsp_r_data", 32'(r_data), 32'(model_rdata));
            end else begin
                repeat (rsp_dly) begin
                    @(posedge clk);
                    #1;
                end
                tl_d.d_valid  = 1'b1;
                tl_d.d_opcode = (rd ^ bad_op) ? AccessAckData : AccessAck;
                tl_d.d_error  = inj_err;
                tl_d.d_data   = (rd && !bad) ? rd_val : 32'($urandom());
                @(posedge clk);
                #1;
                tl_d.d_valid = 1'b0;
                chk("done_at_rsp_edge", 32'(done), 32'd1);
                chk("busy_fall_at_rsp_edge", 32'(busy), 32'd0);
            end
        end
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        rsp_q.delete();
    endtask

    initial begin
        int sel;
        int md;
        rst_n   = 1'b0;
        go      = 1'b1;
        if_read = 1'b0;
        addr    = 4'h0;
        wdata   = 4'h0;
        tl_d    = '0;
        model_rdata = 4'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'($urandom());
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tl_h !== TL_H2D_DEFAULT) begin
            errors++;
            $display("FAIL tl_o_reset: got %h, want %h", tl_h, TL_H2D_DEFAULT);
        end
        chk("reset_r_data", 32'(r_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // go held high across reset release must not launch
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("held_go_busy", 32'(busy), 32'd0);
        chk("held_go_a_valid", 32'(tl_h.a_valid), 32'd0);

        run_txn(1'b0, 4'h3, 4'hA, 0, 0, 1'b0, 1'b0, M_OK, 1'b0);
        run_txn(1'b1, 4'h3, 4'h0, 0, 0, 1'b0, 1'b0, M_OK, 1'b0);
        run_txn(1'b0, 4'h5, 4'h6, 5, 0, 1'b0, 1'b0, M_OK, 1'b1);
        run_txn(1'b1, 4'h3, 4'h0, 1, 1, 1'b1, 1'b0, M_OK, 1'b0);
        run_txn(1'b1, 4'h5, 4'h0, 0, 2, 1'b0, 1'b0, M_OK, 1'b0);
        run_txn(1'b0, 4'h7, 4'h2, 0, 0, 1'b0, 1'b1, M_OK, 1'b0);
        run_txn(1'b1, 4'h3, 4'h0, 0, 0, 1'b0, 1'b0, M_NO_RSP, 1'b0);
        run_txn(1'b0, 4'h9, 4'h4, 0, 0, 1'b0, 1'b0, M_NO_RDY, 1'b0);
        run_txn(1'b1, 4'h9, 4'h0, 3, 3, 1'b0, 1'b0, M_OK, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 15);
            md  = (sel == 0) ? M_NO_RSP : (sel == 1) ? M_NO_RDY : M_OK;
            run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), md, 1'b0);
        end

        run_txn(1'b1, 4'h5, 4'h0, 0, 0, 1'b0, 1'b0, M_RESET, 1'b0);
        run_txn(1'b1, 4'h3, 4'h0, 0, 1, 1'b0, 1'b0, M_OK, 1'b0);

        chk("handshake_count", handshakes, exp_handshakes);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so a stuck design cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
